// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, error
// causes, FSM states and the wait-counter width helper.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_ACCESS_BYTE = 2'b00,
        MEM_ACCESS_HALF = 2'b01,
        MEM_ACCESS_WORD = 2'b10,
        MEM_ACCESS_BAD  = 2'b11
    } mem_access_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_BAD_SIZE = 2'b11
    } err_cause_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Bits needed to count 0..t, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned t);
        int unsigned w;
        w = $clog2(t + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
// Ports:
//   acc        access size code
//   lane       byte address bits [1:0]
//   sext       sign-extend sub-word loads
//   wdata      LSB-justified store data
//   rdata      raw bus read word
//   be         byte enables
//   wdata_rep  store data replicated across lanes
//   rdata_ext  extracted and extended load data
//   misaligned half/word address not naturally aligned
//   bad_size   size code 11
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]      acc,
    input  logic [1:0]      lane,
    input  logic            sext,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext,
    output logic            misaligned,
    output logic            bad_size
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = rdata[{lane, 3'b000} +: 8];
        half_sel   = rdata[{lane[1], 4'b0000} +: 16];
        be         = 4'b0000;
        wdata_rep  = '0;
        rdata_ext  = '0;
        misaligned = 1'b0;
        bad_size   = 1'b0;
        case (acc)
            MEM_ACCESS_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = sext ? {{24{byte_sel[7]}}, byte_sel} : {24'b0, byte_sel};
            end
            MEM_ACCESS_HALF: begin
                be         = 4'b0011 << {lane[1], 1'b0};
                misaligned = lane[0];
                wdata_rep  = {2{wdata[15:0]}};
                rdata_ext  = sext ? {{16{half_sel[15]}}, half_sel} : {16'b0, half_sel};
            end
            MEM_ACCESS_WORD: begin
                be         = 4'b1111;
                misaligned = |lane;
                wdata_rep  = wdata;
                rdata_ext  = rdata;
            end
            default: bad_size = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: runs one data-bus transaction per decoder request and
// returns aligned, extended load data plus a one-cycle done pulse.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/we_i/acc_i/sext_i/addr_i/wdata_i   request from decoder/ALU
//   rdata_o, done_o, busy_o, err_o, err_cause_o  completion to core
//   bus_req_o/bus_we_o/bus_addr_o/bus_be_o/bus_wdata_o  bus request
//   bus_ready_i, bus_rdata_i  bus acceptance and read word
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  acc_i,
    input  logic        sext_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  err_cause_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam bit          TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    logic [1:0]       acc_q;
    logic [1:0]       lane_q;
    logic             sext_q;
    logic [CNT_W-1:0] wait_cnt;

    logic [1:0]  acc_sel;
    logic [1:0]  lane_sel;
    logic        sext_sel;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic [31:0] rdata_ext;
    logic        misaligned;
    logic        bad_size;

    // Live request while idle, latched request once the bus access is running.
    always_comb begin
        acc_sel  = (state == ST_IDLE) ? acc_i       : acc_q;
        lane_sel = (state == ST_IDLE) ? addr_i[1:0] : lane_q;
        sext_sel = (state == ST_IDLE) ? sext_i      : sext_q;
    end

    lsu_align u_align (
        .acc        (acc_sel),
        .lane       (lane_sel),
        .sext       (sext_sel),
        .wdata      (wdata_i),
        .rdata      (bus_rdata_i),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .rdata_ext  (rdata_ext),
        .misaligned (misaligned),
        .bad_size   (bad_size)
    );

    // Transaction FSM with registered outputs and bus wait counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            acc_q       <= 2'b00;
            lane_q      <= 2'b00;
            sext_q      <= 1'b0;
            wait_cnt    <= '0;
            rdata_o     <= '0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b0;
            err_cause_o <= ERR_NONE;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'b0000;
            bus_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        busy_o <= 1'b1;
                        if (bad_size || misaligned) begin
                            // Illegal request completes without touching the bus.
                            state       <= ST_DONE;
                            done_o      <= 1'b1;
                            err_o       <= 1'b1;
                            err_cause_o <= bad_size ? ERR_BAD_SIZE : ERR_MISALIGN;
                            rdata_o     <= '0;
                        end else begin
                            state       <= ST_BUS;
                            bus_req_o   <= 1'b1;
                            bus_we_o    <= we_i;
                            bus_addr_o  <= {addr_i[31:2], 2'b00};
                            bus_be_o    <= be;
                            bus_wdata_o <= wdata_rep;
                            acc_q       <= acc_i;
                            lane_q      <= addr_i[1:0];
                            sext_q      <= sext_i;
                            wait_cnt    <= '0;
                        end
                    end
                end
                ST_BUS: begin
                    if (bus_ready_i) begin
                        state       <= ST_DONE;
                        bus_req_o   <= 1'b0;
                        done_o      <= 1'b1;
                        err_cause_o <= ERR_NONE;
                        if (!bus_we_o) begin
                            rdata_o <= rdata_ext;
                        end
                    end else if (TMO_EN && (wait_cnt == CNT_LAST)) begin
                        // This wait cycle brings the count to TIMEOUT_CYCLES.
                        state       <= ST_DONE;
                        bus_req_o   <= 1'b0;
                        done_o      <= 1'b1;
                        err_o       <= 1'b1;
                        err_cause_o <= ERR_TIMEOUT;
                        rdata_o     <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, randomized
// transactions against a behavioural model, and multi-cycle corner cases.
module tb_lsu;

    localparam int TMO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  acc_i;
    logic        sext_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        busy_o;
    logic        err_o;
    logic [1:0]  err_cause_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_rdata = '0;

    always #5 clk_i = ~clk_i;

    lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .acc_i       (acc_i),
        .sext_i      (sext_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .done_o      (done_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .err_cause_o (err_cause_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ready_i (bus_ready_i),
        .bus_rdata_i (bus_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [1:0]  acc;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          wait_n;
        logic [31:0] e_rdata;
        logic [1:0]  e_cause;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        int          e_busc;
        int          e_donec;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: derive outcome of one request from the size/alignment/wait rules.
    task automatic model(input logic we, input logic [1:0] acc, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int wait_n,
                         output logic [1:0] cause, output logic [3:0] be,
                         output logic [31:0] wrep, output int busc, output int donec);
        int nb;
        int lane;
        logic [31:0] val;
        logic [31:0] mask;
        nb   = 1 << acc;
        lane = int'(addr % 4);
        be   = '0;
        wrep = '0;
        if (acc == 2'b11) begin
            cause = 2'b11; busc = 0; donec = 1; m_rdata = '0;
        end else if ((addr % nb) != 0) begin
            cause = 2'b01; busc = 0; donec = 1; m_rdata = '0;
        end else begin
            be = 4'(((1 << nb) - 1) << lane);
            for (int i = 0; i < 4; i++)
                wrep[8*i +: 8] = 8'(wdata >> (8 * (i % nb)));
            if (wait_n >= TMO) begin
                cause = 2'b10; busc = TMO; donec = TMO + 1; m_rdata = '0;
            end else begin
                cause = 2'b00; busc = wait_n + 1; donec = wait_n + 2;
                mask = 32'hFFFF_FFFF >> (32 - 8 * nb);
                val  = (rdata >> (8 * lane)) & mask;
                if (sext && val[8*nb-1]) val = val | ~mask;
                if (!we) m_rdata = val;
            end
        end
    endtask

    // Drive one request from cycle 0 and check everything it produces.
    task automatic run_txn(input string tag, input logic we, input logic [1:0] acc,
                           input logic sext, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int wait_n, input logic [31:0] e_rdata,
                           input logic [1:0] e_cause, input logic [3:0] e_be,
                           input logic [31:0] e_wdata, input int e_busc, input int e_donec);
        int busc;
        int donec;
        logic er;
        logic [1:0] cause;
        logic [31:0] rd;
        we_i = we; acc_i = acc; sext_i = sext; addr_i = addr; wdata_i = wdata;
        bus_rdata_i = rdata; bus_ready_i = 1'b0; req_i = 1'b1;
        busc = 0; donec = -1; er = 1'b0; cause = 2'b00; rd = '0;
        for (int cyc = 1; cyc <= 40 && donec < 0; cyc++) begin
            @(posedge clk_i); #1;
            bus_ready_i = 1'b0;
            if (bus_req_o) begin
                busc++;
                check({tag, " bus_addr"}, bus_addr_o, {addr[31:2], 2'b00});
                check({tag, " bus_be"}, 32'(bus_be_o), 32'(e_be));
                check({tag, " bus_wdata"}, bus_wdata_o, e_wdata);
                check({tag, " bus_we"}, 32'(bus_we_o), 32'(we));
                bus_ready_i = (busc > wait_n);
            end
            if (done_o) begin
                donec = cyc; er = err_o; cause = err_cause_o; rd = rdata_o;
                req_i = 1'b0;
            end
        end
        req_i = 1'b0;
        bus_ready_i = 1'b0;
        check({tag, " done_cycle"}, 32'(donec), 32'(e_donec));
        check({tag, " bus_cycles"}, 32'(busc), 32'(e_busc));
        check({tag, " err"}, 32'(er), 32'(e_cause != 2'b00));
        check({tag, " cause"}, 32'(cause), 32'(e_cause));
        check({tag, " rdata"}, rd, e_rdata);
        @(posedge clk_i); #1;
        check({tag, " busy_after"}, 32'(busy_o), 32'd0);
        check({tag, " done_after"}, 32'(done_o), 32'd0);
    endtask

    task automatic run_model(input string tag, input logic we, input logic [1:0] acc,
                             input logic sext, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int wait_n);
        logic [1:0] c;
        logic [3:0] b;
        logic [31:0] w;
        int bc;
        int dc;
        model(we, acc, sext, addr, wdata, rdata, wait_n, c, b, w, bc, dc);
        run_txn(tag, we, acc, sext, addr, wdata, rdata, wait_n, m_rdata, c, b, w, bc, dc);
    endtask

    initial begin
        int d1;
        int d2;
        int nd;
        int nb;
        logic seen;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; acc_i = 2'b00; sext_i = 1'b0;
        addr_i = '0; wdata_i = '0; bus_ready_i = 1'b0; bus_rdata_i = '0;

        //               we   acc    sx   addr          wdata         rdata        wait  e_rdata       cause  be       e_wdata      busc done
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0000_0000, 32'h80FF_FF7F, 0,  32'hFFFF_FF80, 2'b00, 4'b1000, 32'h0000_0000, 1, 2};
        tbl[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 32'h1234_5678, 3,  32'hFFFF_FF80, 2'b00, 4'b1100, 32'hBEEF_BEEF, 4, 5};
        tbl[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000, 2'b01, 4'b0000, 32'h0000_0000, 0, 1};
        tbl[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_1234, 32'h8001_0000, 0,  32'h0000_8001, 2'b00, 4'b1100, 32'h1234_1234, 1, 2};
        tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'hCAFE_F00D, 32'h5555_5555, 99, 32'h0000_0000, 2'b10, 4'b1111, 32'hCAFE_F00D, 4, 5};
        tbl[5]  = '{1'b0, 2'b00, 1'b0, 32'h0000_5001, 32'h0000_0000, 32'h0000_A500, 1,  32'h0000_00A5, 2'b00, 4'b0010, 32'h0000_0000, 2, 3};
        tbl[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_6000, 32'h0000_0000, 32'h1234_F00F, 2,  32'hFFFF_F00F, 2'b00, 4'b0011, 32'h0000_0000, 3, 4};
        tbl[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_7002, 32'h1122_3344, 32'h0000_0000, 0,  32'hFFFF_F00F, 2'b00, 4'b0100, 32'h4444_4444, 1, 2};
        tbl[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_8000, 32'hA5A5_5A5A, 32'h0000_0000, 1,  32'hFFFF_F00F, 2'b00, 4'b1111, 32'hA5A5_5A5A, 2, 3};
        tbl[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_9001, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000, 2'b01, 4'b0000, 32'h0000_0000, 0, 1};
        tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h0000_A000, 32'h0000_0000, 32'h0000_0000, 0,  32'h0000_0000, 2'b11, 4'b0000, 32'h0000_0000, 0, 1};
        tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h0000_B004, 32'h0000_0000, 32'h89AB_CDEF, 3,  32'h89AB_CDEF, 2'b00, 4'b1111, 32'h0000_0000, 4, 5};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst rdata", rdata_o, 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst cause", 32'(err_cause_o), 32'd0);
        check("rst bus_req", 32'(bus_req_o), 32'd0);
        check("rst bus_be", 32'(bus_be_o), 32'd0);
        rst_i = 1'b0;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].acc, tbl[i].sext, tbl[i].addr,
                    tbl[i].wdata, tbl[i].rdata, tbl[i].wait_n, tbl[i].e_rdata, tbl[i].e_cause,
                    tbl[i].e_be, tbl[i].e_wdata, tbl[i].e_busc, tbl[i].e_donec);
            m_rdata = tbl[i].e_rdata;
        end

        // Randomized transactions against the model
        for (int i = 0; i < 60; i++) begin
            logic [1:0] a;
            a = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a,
                      1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                      int'($urandom_range(0, 5)));
        end

        // Bad size with req held through DONE: exactly one more transaction
        we_i = 1'b0; acc_i = 2'b11; addr_i = 32'h0000_F000; req_i = 1'b1;
        d1 = -1; d2 = -1; nd = 0; nb = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk_i); #1;
            if (bus_req_o) nb++;
            if (done_o) begin
                nd++;
                check("hold cause", 32'(err_cause_o), 32'd3);
                if (d1 < 0) d1 = cyc; else d2 = cyc;
            end
            if (cyc == 3) req_i = 1'b0;
        end
        check("hold done_count", 32'(nd), 32'd2);
        check("hold first_done", 32'(d1), 32'd1);
        check("hold second_done", 32'(d2), 32'd3);
        check("hold bus_req_count", 32'(nb), 32'd0);
        m_rdata = '0;

        // Reset in the second BUS wait cycle
        run_model("pre_rst", 1'b0, 2'b10, 1'b0, 32'h0000_D000, 32'h0, 32'h1357_9BDF, 0);
        we_i = 1'b0; acc_i = 2'b10; addr_i = 32'h0000_E000; req_i = 1'b1; bus_ready_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_mid bus_req1", 32'(bus_req_o), 32'd1);
        @(posedge clk_i); #1;
        check("rst_mid bus_req2", 32'(bus_req_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; req_i = 1'b0;
        check("rst_mid bus_req", 32'(bus_req_o), 32'd0);
        check("rst_mid busy", 32'(busy_o), 32'd0);
        check("rst_mid done", 32'(done_o), 32'd0);
        check("rst_mid rdata", rdata_o, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk_i); #1;
            seen = seen | done_o | bus_req_o;
        end
        check("rst_mid quiet", 32'(seen), 32'd0);
        m_rdata = '0;
        run_model("post_rst", 1'b0, 2'b01, 1'b1, 32'h0000_E002, 32'h0, 32'h9ABC_0000, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
